// File: rtl/dand_soc_simple.sv
// Bring-up SoC stand-in: boot banner plus UART 8N1 echo through a small RX FIFO.
// One completed TX frame counts as one retired operation.
module dand_soc_simple #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        io_axiClk,
  input  logic        io_reset,
  input  logic        io_uart_rxd,
  output logic        io_uart_txd,
  output logic        io_retireValid,
  output logic [31:0] io_retireCount,
  output logic        io_rxOverflow
);
  localparam int CW   = $clog2(CLK_DIV);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HALF = CLK_DIV / 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [7:0] banner_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    banner_byte = 8'h44;
      3'd1:    banner_byte = 8'h61;
      3'd2:    banner_byte = 8'h6E;
      3'd3:    banner_byte = 8'h64;
      3'd4:    banner_byte = 8'h53;
      3'd5:    banner_byte = 8'h6F;
      3'd6:    banner_byte = 8'h43;
      default: banner_byte = 8'h0A;
    endcase
  endfunction

  // TX state
  state_t      tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        retire_valid_q, retire_valid_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic [3:0]  banner_idx_q, banner_idx_d;

  // RX state
  logic        rx_sync1_q, rx_sync2_q;
  state_t      rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_wait_q, rx_wait_d;

  // FIFO state
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [AW:0] fifo_cnt_q, fifo_cnt_d;
  logic        overflow_q, overflow_d;

  logic        fifo_push, fifo_pop, push_ok, fifo_empty, fifo_full;
  logic        banner_pending, tx_avail, tx_load;
  logic [7:0]  tx_next_byte, fifo_head;

  assign fifo_empty     = (fifo_cnt_q == '0);
  assign fifo_full      = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_head      = fifo_mem_q[fifo_rd_q];
  assign banner_pending = ~banner_idx_q[3];
  assign tx_avail       = banner_pending | ~fifo_empty;
  assign tx_next_byte   = banner_pending ? banner_byte(banner_idx_q[2:0]) : fifo_head;

  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_cnt_q;
    tx_bit_d       = tx_bit_q;
    tx_shift_d     = tx_shift_q;
    txd_d          = txd_q;
    banner_idx_d   = banner_idx_q;
    retire_valid_d = 1'b0;
    tx_load        = 1'b0;
    fifo_pop       = 1'b0;
    case (tx_state_q)
      S_IDLE: tx_load = tx_avail;
      S_START: begin
        if (tx_cnt_q == CW'(CLK_DIV-1)) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      S_DATA: begin
        if (tx_cnt_q == CW'(CLK_DIV-1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      S_STOP: begin
        if (tx_cnt_q == CW'(CLK_DIV-1)) begin
          tx_load    = tx_avail;
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
          // Registered pulse lands on the final stop-bit cycle.
          retire_valid_d = (tx_cnt_q == CW'(CLK_DIV-2));
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      txd_d      = 1'b0;
      tx_shift_d = tx_next_byte;
      if (banner_pending) banner_idx_d = banner_idx_q + 4'd1;
      else                fifo_pop     = 1'b1;
    end
    retire_count_d = retire_valid_d ? retire_count_q + 32'd1 : retire_count_q;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    fifo_push  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == CW'(HALF-1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      S_DATA: begin
        if (rx_cnt_q == CW'(CLK_DIV-1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      S_STOP: begin
        // A framing error parks here until the line idles so it cannot re-trigger.
        if (rx_wait_q) begin
          if (rx_sync2_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_cnt_q == CW'(CLK_DIV-1)) begin
          rx_cnt_d = '0;
          if (rx_sync2_q) begin
            fifo_push  = 1'b1;
            rx_state_d = S_IDLE;
          end else rx_wait_d = 1'b1;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_ok    = fifo_push & (~fifo_full | fifo_pop);
    overflow_d = overflow_q | (fifo_push & ~push_ok);
    fifo_wr_d  = push_ok  ? fifo_wr_q + AW'(1) : fifo_wr_q;
    fifo_rd_d  = fifo_pop ? fifo_rd_q + AW'(1) : fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_ok && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push_ok && fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge io_axiClk) begin
    if (push_ok) fifo_mem_q[fifo_wr_q] <= rx_shift_q;
  end

  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      tx_state_q     <= S_IDLE;
      tx_cnt_q       <= '0;
      tx_bit_q       <= '0;
      tx_shift_q     <= '0;
      txd_q          <= 1'b1;
      retire_valid_q <= 1'b0;
      retire_count_q <= '0;
      banner_idx_q   <= '0;
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_state_q     <= S_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_wait_q      <= 1'b0;
      fifo_wr_q      <= '0;
      fifo_rd_q      <= '0;
      fifo_cnt_q     <= '0;
      overflow_q     <= 1'b0;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_shift_q     <= tx_shift_d;
      txd_q          <= txd_d;
      retire_valid_q <= retire_valid_d;
      retire_count_q <= retire_count_d;
      banner_idx_q   <= banner_idx_d;
      rx_sync1_q     <= io_uart_rxd;
      rx_sync2_q     <= rx_sync1_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_wait_q      <= rx_wait_d;
      fifo_wr_q      <= fifo_wr_d;
      fifo_rd_q      <= fifo_rd_d;
      fifo_cnt_q     <= fifo_cnt_d;
      overflow_q     <= overflow_d;
    end
  end

  assign io_uart_txd    = txd_q;
  assign io_retireValid = retire_valid_q;
  assign io_retireCount = retire_count_q;
  assign io_rxOverflow  = overflow_q;
endmodule

// File: tb/tb_dand_soc_simple.sv
// Directed bench for dand_soc_simple: decodes txd, drives rxd frames, checks
// banner, echo, FIFO overflow/boundary, framing errors and mid-frame reset.
module tb_dand_soc_simple;
  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;

  logic        clk;
  logic        rst;
  logic        rxd;
  logic        txd;
  logic        rv;
  logic [31:0] rc;
  logic        ovf;

  dand_soc_simple #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .io_axiClk     (clk),
    .io_reset      (rst),
    .io_uart_rxd   (rxd),
    .io_uart_txd   (txd),
    .io_retireValid(rv),
    .io_retireCount(rc),
    .io_rxOverflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // txd decoder: records each frame's byte and the cycle its start bit appeared.
  logic [7:0] tx_bytes[$];
  int         tx_starts[$];
  int         rv_pulses = 0;
  int         rv_long = 0;
  int         tx_bad = 0;
  logic       rv_prev = 1'b0;
  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  int         mon_start = 0;
  logic [7:0] mon_sh = '0;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy  = 1'b0;
      rv_prev   = 1'b0;
      rv_pulses = 0;
      tx_bytes.delete();
      tx_starts.delete();
    end else begin
      if (rv) begin
        rv_pulses++;
        if (rv_prev) rv_long++;
      end
      rv_prev = rv;
      if (!mon_busy) begin
        if (!txd) begin
          mon_busy  = 1'b1;
          mon_cnt   = 0;
          mon_start = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CLK_DIV == CLK_DIV / 2) begin
          if (mon_cnt / CLK_DIV >= 1 && mon_cnt / CLK_DIV <= 8) begin
            mon_sh[mon_cnt / CLK_DIV - 1] = txd;
          end else if (mon_cnt / CLK_DIV == 9) begin
            if (txd) begin
              tx_bytes.push_back(mon_sh);
              tx_starts.push_back(mon_start);
            end else tx_bad++;
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (n) @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_count", rc, 32'd0);
    check("reset_retire", {31'd0, rv}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         n_echo;
  } rx_vec_t;

  rx_vec_t    vecs[5];
  logic [7:0] banner[8];
  int         n0, t0;
  logic [31:0] c0;

  initial begin
    banner = '{8'h44, 8'h61, 8'h6E, 8'h64, 8'h53, 8'h6F, 8'h43, 8'h0A};
    vecs[0] = '{data: 8'hA5, stop: 1'b1, n_echo: 1};
    vecs[1] = '{data: 8'h00, stop: 1'b1, n_echo: 1};
    vecs[2] = '{data: 8'h3C, stop: 1'b0, n_echo: 0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, n_echo: 1};
    vecs[4] = '{data: 8'h80, stop: 1'b1, n_echo: 1};

    rst = 1'b1;
    rxd = 1'b1;

    // Banner after a 25-cycle reset
    do_reset(25);
    wait_until(1);
    check("first_start_bit", {31'd0, txd}, 32'd0);
    wait_until(1279);
    check("count_before_last", rc, 32'd7);
    wait_until(1280);
    check("count_at_1280", rc, 32'd8);
    check("retire_at_1280", {31'd0, rv}, 32'd1);
    wait_until(1300);
    check("banner_len", tx_bytes.size(), 32'd8);
    for (int i = 0; i < 8 && i < tx_bytes.size(); i++) begin
      check($sformatf("banner_byte%0d", i), {24'd0, tx_bytes[i]}, {24'd0, banner[i]});
      check($sformatf("banner_start%0d", i), tx_starts[i], 1 + i * FRAME);
    end
    check("banner_pulses", rv_pulses, 32'd8);
    check("idle_txd", {31'd0, txd}, 32'd1);

    // Echo vectors, including a framing error
    for (int v = 0; v < 5; v++) begin
      n0 = tx_bytes.size();
      c0 = rc;
      t0 = cyc;
      send_byte(vecs[v].data, vecs[v].stop);
      wait_until(t0 + 2 * FRAME + 20);
      check($sformatf("echo_n_v%0d", v), tx_bytes.size(), n0 + vecs[v].n_echo);
      check($sformatf("echo_cnt_v%0d", v), rc, c0 + 32'(vecs[v].n_echo));
      if (vecs[v].n_echo == 1 && tx_bytes.size() > n0) begin
        check($sformatf("echo_byte_v%0d", v), {24'd0, tx_bytes[n0]}, {24'd0, vecs[v].data});
        check($sformatf("echo_lat_v%0d", v), 32'(tx_starts[n0] - t0 <= 2 + FRAME + 2), 32'd1);
      end
    end

    // Short low glitch must not produce a byte
    n0 = tx_bytes.size();
    c0 = rc;
    rxd = 1'b0;
    repeat (CLK_DIV / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    check("glitch_n", tx_bytes.size(), n0);
    check("glitch_cnt", rc, c0);
    check("glitch_ovf", {31'd0, ovf}, 32'd0);

    // Three bytes during the banner are echoed right after it
    do_reset(5);
    wait_until(40);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    wait_until(8 * FRAME + 3 * FRAME + 20);
    check("q3_len", tx_bytes.size(), 32'd11);
    for (int i = 0; i < 3 && 8 + i < tx_bytes.size(); i++) begin
      check($sformatf("q3_byte%0d", i), {24'd0, tx_bytes[8 + i]}, 32'h11 * (i + 1));
      check($sformatf("q3_start%0d", i), tx_starts[8 + i], 1 + (8 + i) * FRAME);
    end
    check("q3_count", rc, 32'd11);
    check("q3_ovf", {31'd0, ovf}, 32'd0);

    // Six bytes during the banner: four kept, overflow sticky
    do_reset(5);
    wait_until(20);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    wait_until(8 * FRAME + 4 * FRAME + 20);
    check("ovf_len", tx_bytes.size(), 32'd12);
    for (int i = 0; i < 4 && 8 + i < tx_bytes.size(); i++)
      check($sformatf("ovf_byte%0d", i), {24'd0, tx_bytes[8 + i]}, 32'(i + 1));
    check("ovf_count", rc, 32'd12);
    wait_until(8 * FRAME + 6 * FRAME + 40);
    check("ovf_len_late", tx_bytes.size(), 32'd12);
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Push into a full FIFO on the same edge as the first echo pop
    do_reset(5);
    wait_until(20);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    wait_until(8 * FRAME + 1 - 155);
    send_byte(8'h55, 1'b1);
    wait_until(8 * FRAME + 5 * FRAME + 20);
    check("full_pp_len", tx_bytes.size(), 32'd13);
    if (tx_bytes.size() > 12) check("full_pp_last", {24'd0, tx_bytes[12]}, 32'h55);
    check("full_pp_ovf", {31'd0, ovf}, 32'd0);

    // Reset during the third banner byte
    do_reset(5);
    wait_until(2 * FRAME + 1 + CLK_DIV + 4);
    check("mid_txd_low", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_txd", {31'd0, txd}, 32'd1);
    repeat (2500) @(negedge clk);
    check("long_rst_txd", {31'd0, txd}, 32'd1);
    check("long_rst_count", rc, 32'd0);
    rst = 1'b0;
    wait_until(1);
    check("restart_start", {31'd0, txd}, 32'd0);
    wait_until(FRAME + 10);
    check("restart_len", tx_bytes.size(), 32'd1);
    if (tx_bytes.size() > 0) begin
      check("restart_byte", {24'd0, tx_bytes[0]}, 32'h44);
      check("restart_at", tx_starts[0], 32'd1);
    end
    check("restart_count", rc, 32'd1);

    check("retire_single_cycle", rv_long, 32'd0);
    check("tx_framing", tx_bad, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
